clap_pattern_ctrl: RTL and testbench

- Control and sequencing block for the 7-bit clap detector.
- Holds the detector in reset during microphone warm-up, then arms it.
- Groups clap pulses into 1/2/3-clap patterns and delivers each pattern as a command over a valid/ready handshake.
- Applies a lockout after each command so clap echoes do not start a new pattern; sits between the detector and the application logic (LED/toggle control).

---
 rtl/clap_ctrl_pkg.sv | 26 ++
 rtl/clap_pulse_sync.sv | 32 +++
 rtl/clap_pattern_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_clap_pattern_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clap_ctrl_pkg.sv
// Shared types and helpers for the clap pattern controller.
// State codes, command width and timer sizing.
package clap_ctrl_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_ARMED   = 3'd2,
        ST_COLLECT = 3'd3,
        ST_EMIT    = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_e;

    // Width of the one timer shared by warm-up, gap and lockout phases.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/clap_pulse_sync.sv
// Brings the detector clap pulse into clk_i and makes a one-cycle event.
// Two sync flops, an edge-history flop and a registered edge strobe.
module clap_pulse_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;

    // Synchronize, then strobe once per rising edge of the synced level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/clap_pattern_ctrl.sv
// Clap pattern controller: warm-up, clap grouping, command handshake, lockout.
// Optional debug ports enabled by defining CLAP_PATTERN_CTRL_DBG_EN.
module clap_pattern_ctrl
    import clap_ctrl_pkg::*;
#(
    parameter int WARMUP_CYC  = 1_000_000,
    parameter int GAP_MAX     = 60_000_000,
    parameter int LOCKOUT_CYC = 30_000_000,
    parameter int MAX_CLAPS   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             clap_pulse_i,
    output logic             det_rst_o,
    output logic             cmd_valid_o,
    output logic [CMD_W-1:0] cmd_o,
    input  logic             cmd_ready_i,
    output logic             busy_o
`ifdef CLAP_PATTERN_CTRL_DBG_EN
    ,
    output logic [2:0]       dbg_state_o,
    output logic [7:0]       dbg_drop_cnt_o
`endif
);

    localparam int TW = timer_width(WARMUP_CYC, GAP_MAX, LOCKOUT_CYC);

    localparam logic [TW-1:0]    WARM_LAST = TW'(WARMUP_CYC - 1);
    localparam logic [TW-1:0]    GAP_LAST  = TW'(GAP_MAX - 1);
    localparam logic [TW-1:0]    LOCK_LAST = TW'(LOCKOUT_CYC - 1);
    localparam logic [CMD_W-1:0] MAX_C     = CMD_W'(MAX_CLAPS);
    localparam logic [CMD_W-1:0] ONE_C     = CMD_W'(1);

    logic             clap_evt;
    state_e           state_q;
    logic [TW-1:0]    timer_q;
    logic [TW-1:0]    timer_d;
    logic [CMD_W-1:0] count_q;
    logic [CMD_W-1:0] count_d;
    logic [CMD_W-1:0] cmd_q;
    logic             valid_q;
    logic             det_rst_q;
    logic             busy_q;

    clap_pulse_sync u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (clap_pulse_i),
        .pulse_o (clap_evt)
    );

    // Next timer value and saturating next clap count.
    always_comb begin
        timer_d = timer_q + 1'b1;
        count_d = (count_q == MAX_C) ? count_q : count_q + 1'b1;
    end

    // Main sequencer with registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_OFF;
            timer_q   <= '0;
            count_q   <= '0;
            cmd_q     <= '0;
            valid_q   <= 1'b0;
            det_rst_q <= 1'b1;
            busy_q    <= 1'b0;
        end else if (!enable_i) begin
            state_q   <= ST_OFF;
            timer_q   <= '0;
            count_q   <= '0;
            cmd_q     <= '0;
            valid_q   <= 1'b0;
            det_rst_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_q   <= ST_WARMUP;
                    timer_q   <= '0;
                    det_rst_q <= 1'b1;
                    busy_q    <= 1'b1;
                end
                ST_WARMUP: begin
                    if (timer_q == WARM_LAST) begin
                        state_q   <= ST_ARMED;
                        timer_q   <= '0;
                        det_rst_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                ST_ARMED: begin
                    if (clap_evt) begin
                        busy_q  <= 1'b1;
                        timer_q <= '0;
                        if (MAX_C == ONE_C) begin
                            state_q <= ST_EMIT;
                            count_q <= ONE_C;
                            cmd_q   <= ONE_C;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_COLLECT;
                            count_q <= ONE_C;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (clap_evt) begin
                        count_q <= count_d;
                        timer_q <= '0;
                        if (count_d == MAX_C) begin
                            state_q <= ST_EMIT;
                            cmd_q   <= MAX_C;
                            valid_q <= 1'b1;
                        end
                    end else if (timer_q == GAP_LAST) begin
                        state_q <= ST_EMIT;
                        cmd_q   <= count_q;
                        valid_q <= 1'b1;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                ST_EMIT: begin
                    if (valid_q && cmd_ready_i) begin
                        state_q <= ST_LOCKOUT;
                        valid_q <= 1'b0;
                        timer_q <= '0;
                        count_q <= '0;
                    end
                end
                ST_LOCKOUT: begin
                    if (timer_q == LOCK_LAST) begin
                        state_q <= ST_ARMED;
                        timer_q <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                default: begin
                    state_q   <= ST_OFF;
                    timer_q   <= '0;
                    count_q   <= '0;
                    valid_q   <= 1'b0;
                    det_rst_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign det_rst_o   = det_rst_q;
    assign cmd_valid_o = valid_q;
    assign cmd_o       = cmd_q;
    assign busy_o      = busy_q;

`ifdef CLAP_PATTERN_CTRL_DBG_EN
    logic [7:0] drop_cnt_q;
    logic       drop_hit;

    assign drop_hit = clap_evt &&
                      ((state_q == ST_WARMUP) ||
                       (state_q == ST_EMIT) ||
                       (state_q == ST_LOCKOUT));

    // Saturating count of claps thrown away; survives enable toggles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else if (drop_hit && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign dbg_state_o    = state_q;
    assign dbg_drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_clap_pattern_ctrl.sv
// Directed bench for clap_pattern_ctrl with small timing parameters.
// Debug ports checked only when CLAP_PATTERN_CTRL_DBG_EN is defined.
module tb_clap_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       enable_i;
    logic       clap_pulse_i;
    logic       det_rst_o;
    logic       cmd_valid_o;
    logic [1:0] cmd_o;
    logic       cmd_ready_i;
    logic       busy_o;
`ifdef CLAP_PATTERN_CTRL_DBG_EN
    logic [2:0] dbg_state_o;
    logic [7:0] dbg_drop_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clap_pattern_ctrl #(
        .WARMUP_CYC  (10),
        .GAP_MAX     (20),
        .LOCKOUT_CYC (8),
        .MAX_CLAPS   (3)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .clap_pulse_i (clap_pulse_i),
        .det_rst_o    (det_rst_o),
        .cmd_valid_o  (cmd_valid_o),
        .cmd_o        (cmd_o),
        .cmd_ready_i  (cmd_ready_i),
        .busy_o       (busy_o)
`ifdef CLAP_PATTERN_CTRL_DBG_EN
        ,
        .dbg_state_o    (dbg_state_o),
        .dbg_drop_cnt_o (dbg_drop_cnt_o)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i        = 1'b1;
        enable_i     = 1'b0;
        clap_pulse_i = 1'b0;
        cmd_ready_i  = 1'b1;
        tick();
        tick();
        total++;
        if (det_rst_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_det_rst got=%b want=1", det_rst_o);
        end
        total++;
        if (cmd_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b want=0", cmd_valid_o);
        end
        total++;
        if (cmd_o !== 2'd0) begin
            bad++;
            $display("FAIL reset_cmd got=%0d want=0", cmd_o);
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b want=0", busy_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    // Enable after edge 0; WARMUP from edge 1, ARMED at edge 11.
    task automatic test_warmup();
        int bad_rst;
        int seen_v;
        bad_rst  = 0;
        seen_v   = 0;
        enable_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) clap_pulse_i = 1'b1;
            if (k == 4) clap_pulse_i = 1'b0;
            if (det_rst_o !== 1'b1 || busy_o !== 1'b1) bad_rst++;
        end
        total++;
        if (bad_rst != 0) begin
            bad++;
            $display("FAIL warmup_hold got=%0d want=0 bad cycles", bad_rst);
        end
        tick();
        total++;
        if (det_rst_o !== 1'b0) begin
            bad++;
            $display("FAIL warmup_arm_det_rst got=%b want=0", det_rst_o);
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL warmup_arm_busy got=%b want=0", busy_o);
        end
        for (int k = 0; k < 30; k++) begin
            tick();
            if (cmd_valid_o === 1'b1) seen_v++;
        end
        total++;
        if (seen_v != 0) begin
            bad++;
            $display("FAIL warmup_clap_ignored got=%0d want=0", seen_v);
        end
`ifdef CLAP_PATTERN_CTRL_DBG_EN
        total++;
        if (dbg_drop_cnt_o !== 8'd1) begin
            bad++;
            $display("FAIL warmup_drop got=%0d want=1", dbg_drop_cnt_o);
        end
`endif
    endtask

    // Rise after edge 0, evt sampled at edge 4, timeout EMIT at edge 24.
    task automatic test_single();
        clap_pulse_i = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (k == 32) clap_pulse_i = 1'b0;
            if (k == 23) begin
                total++;
                if (cmd_valid_o !== 1'b0) begin
                    bad++;
                    $display("FAIL single_early got=%b want=0", cmd_valid_o);
                end
            end
            if (k == 24) begin
                total++;
                if (cmd_valid_o !== 1'b1 || cmd_o !== 2'd1) begin
                    bad++;
                    $display("FAIL single_emit got=%b/%0d want=1/1",
                             cmd_valid_o, cmd_o);
                end
            end
            if (k == 25) begin
                total++;
                if (cmd_valid_o !== 1'b0 || busy_o !== 1'b1) begin
                    bad++;
                    $display("FAIL single_lock got=%b/%b want=0/1",
                             cmd_valid_o, busy_o);
                end
            end
            if (k == 32) begin
                total++;
                if (busy_o !== 1'b1) begin
                    bad++;
                    $display("FAIL single_lock_end got=%b want=1", busy_o);
                end
            end
            if (k == 33) begin
                total++;
                if (busy_o !== 1'b0) begin
                    bad++;
                    $display("FAIL single_rearm got=%b want=0", busy_o);
                end
            end
        end
    endtask

    // Rises after edges 0 and 12; second evt at edge 16, EMIT at 36.
    task automatic test_double();
        clap_pulse_i = 1'b1;
        for (int k = 1; k <= 46; k++) begin
            tick();
            clap_pulse_i = (k < 4) || (k >= 12 && k < 16);
            if (k == 35) begin
                total++;
                if (cmd_valid_o !== 1'b0) begin
                    bad++;
                    $display("FAIL double_early got=%b want=0", cmd_valid_o);
                end
            end
            if (k == 36) begin
                total++;
                if (cmd_valid_o !== 1'b1 || cmd_o !== 2'd2) begin
                    bad++;
                    $display("FAIL double_emit got=%b/%0d want=1/2",
                             cmd_valid_o, cmd_o);
                end
            end
            if (k == 46) begin
                total++;
                if (busy_o !== 1'b0) begin
                    bad++;
                    $display("FAIL double_rearm got=%b want=0", busy_o);
                end
            end
        end
    endtask

    // Rises after edges 0,5,10; third evt at edge 14 emits at once.
    task automatic test_max_claps();
        int seen_v;
        seen_v       = 0;
        clap_pulse_i = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            clap_pulse_i = (k < 2) || (k >= 5 && k < 7) ||
                           (k >= 10 && k < 12) || (k >= 16 && k < 18);
            if (k == 13) begin
                total++;
                if (cmd_valid_o !== 1'b0) begin
                    bad++;
                    $display("FAIL max_early got=%b want=0", cmd_valid_o);
                end
            end
            if (k == 14) begin
                total++;
                if (cmd_valid_o !== 1'b1 || cmd_o !== 2'd3) begin
                    bad++;
                    $display("FAIL max_emit got=%b/%0d want=1/3",
                             cmd_valid_o, cmd_o);
                end
            end
            if (k >= 15 && cmd_valid_o === 1'b1) seen_v++;
        end
        total++;
        if (seen_v != 0) begin
            bad++;
            $display("FAIL max_fourth_ignored got=%0d want=0", seen_v);
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL max_idle got=%b want=0", busy_o);
        end
`ifdef CLAP_PATTERN_CTRL_DBG_EN
        total++;
        if (dbg_drop_cnt_o !== 8'd2) begin
            bad++;
            $display("FAIL max_drop got=%0d want=2", dbg_drop_cnt_o);
        end
`endif
    endtask

    // Double clap with ready low for 15 EMIT cycles (edges 36..50).
    task automatic test_backpressure();
        int unstable;
        unstable     = 0;
        cmd_ready_i  = 1'b0;
        clap_pulse_i = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            clap_pulse_i = (k < 4) || (k >= 12 && k < 16);
            if (k >= 36 && k <= 50) begin
                if (cmd_valid_o !== 1'b1 || cmd_o !== 2'd2) unstable++;
            end
            if (k == 50) cmd_ready_i = 1'b1;
            if (k == 51) begin
                total++;
                if (cmd_valid_o !== 1'b0 || busy_o !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_transfer got=%b/%b want=0/1",
                             cmd_valid_o, busy_o);
                end
            end
            if (k == 59) begin
                total++;
                if (busy_o !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_rearm got=%b want=0", busy_o);
                end
            end
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL bp_stable got=%0d want=0 bad cycles", unstable);
        end
    endtask

    // Disable while valid; OFF at edge 25, WARMUP 26..35, ARMED at 36.
    task automatic test_abort();
        int bad_rst;
        bad_rst      = 0;
        cmd_ready_i  = 1'b0;
        clap_pulse_i = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            tick();
            clap_pulse_i = (k < 4);
            if (k == 24) begin
                total++;
                if (cmd_valid_o !== 1'b1) begin
                    bad++;
                    $display("FAIL abort_valid got=%b want=1", cmd_valid_o);
                end
                enable_i = 1'b0;
            end
            if (k == 25) begin
                total++;
                if (cmd_valid_o !== 1'b0 || det_rst_o !== 1'b1 ||
                    busy_o !== 1'b0) begin
                    bad++;
                    $display("FAIL abort_off got=%b/%b/%b want=0/1/0",
                             cmd_valid_o, det_rst_o, busy_o);
                end
`ifdef CLAP_PATTERN_CTRL_DBG_EN
                total++;
                if (dbg_state_o !== 3'd0) begin
                    bad++;
                    $display("FAIL abort_state got=%0d want=0", dbg_state_o);
                end
`endif
                enable_i    = 1'b1;
                cmd_ready_i = 1'b1;
            end
            if (k >= 26 && k <= 35) begin
                if (det_rst_o !== 1'b1 || busy_o !== 1'b1) bad_rst++;
            end
            if (k == 36) begin
                total++;
                if (det_rst_o !== 1'b0 || busy_o !== 1'b0) begin
                    bad++;
                    $display("FAIL abort_rearm got=%b/%b want=0/0",
                             det_rst_o, busy_o);
                end
            end
        end
        total++;
        if (bad_rst != 0) begin
            bad++;
            $display("FAIL abort_rewarm got=%0d want=0 bad cycles", bad_rst);
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_single();
        test_double();
        test_max_claps();
        test_backpressure();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
